// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op/state encodings, bit positions.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } csr_state_e;

  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MTVAL      = 12'h343;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MTAGS      = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;

  localparam int MSTATUS_MIE   = 3;
  localparam int MTAGS_EN      = 0;
  localparam int MTAGS_IRQ_CLR = 1;
  localparam int MTAGS_IF_EN   = 2;

  // RS/RC with a zero operand is a pure read and must not count as a write.
  function automatic logic csr_writes(csr_op_e op, logic [31:0] d);
    return (op == CSR_OP_RW) || ((op == CSR_OP_RS || op == CSR_OP_RC) && d != '0);
  endfunction

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old, logic [31:0] d);
    case (op)
      CSR_OP_RW: return d;
      CSR_OP_RS: return old | d;
      CSR_OP_RC: return old & ~d;
      default:   return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_if.sv
// Request/response and side-band bundle between the execute stage and the CSR unit.
interface csr_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  csr_en_i;
  logic [1:0]            csr_op_i;
  logic [ADDR_WIDTH-1:0] csr_addr_i;
  logic [XLEN-1:0]       csr_data_i;
  logic                  instret_i;
  logic [XLEN-1:0]       csr_data_o;
  logic                  csr_busy_o;
  logic                  csr_done_o;
  logic                  csr_illegal_o;
  logic                  csr_irq_en_o;
  logic                  csr_tags_en_o;
  logic                  csr_tags_if_en_o;
  logic                  csr_tags_irq_clear_o;

  modport master (
    output csr_en_i, csr_op_i, csr_addr_i, csr_data_i, instret_i,
    input  csr_data_o, csr_busy_o, csr_done_o, csr_illegal_o,
           csr_irq_en_o, csr_tags_en_o, csr_tags_if_en_o, csr_tags_irq_clear_o
  );

  modport slave (
    input  csr_en_i, csr_op_i, csr_addr_i, csr_data_i, instret_i,
    output csr_data_o, csr_busy_o, csr_done_o, csr_illegal_o,
           csr_irq_en_o, csr_tags_en_o, csr_tags_if_en_o, csr_tags_irq_clear_o
  );
endinterface

// File: rtl/csr_counter.sv
// W-bit event counter with independently writable 32-bit low/high halves.
module csr_counter #(
  parameter int W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);
  localparam int HW = W - 32;

  logic [W-1:0] cnt;

  // A write owns the cycle: the written half takes the value verbatim, nothing carries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_lo) begin
      cnt[31:0] <= wdata;
    end else if (wr_hi) begin
      cnt[W-1:32] <= HW'(wdata);
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign lo = cnt[31:0];
  assign hi = 32'(cnt[W-1:32]);

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR unit: 3-cycle read-modify-write with legality decode and side-band outputs.
// Build option CSR_COUNTERS_EN adds the mcycle/minstret counters (B00/B02/B80/B82).
module csr_file
  import csr_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          ADDR_WIDTH = 12,
  parameter int          HART_ID    = 0,
  parameter int          VENDOR_ID  = 0,
  parameter logic [31:0] MISA_VAL   = 32'h40000100,
  parameter int          CNT_WIDTH  = 64
) (
  input logic  clk_i,
  input logic  rst_i,
  csr_if.slave bus
);
  csr_state_e            state_q, state_d;
  csr_op_e               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q, data_q, rd_val, new_val;
  logic                  exists_q, ro_q, rd_exists, we, illegal, commit, irq_clr_q;
  logic [XLEN-1:0]       mstatus_q, mie_q, mtvec_q, mcounteren_q, mscratch_q;
  logic [XLEN-1:0]       mepc_q, mcause_q, mtval_q, mip_q, mtags_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.csr_en_i) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef CSR_COUNTERS_EN
  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;

  csr_counter #(.W(CNT_WIDTH)) u_mcycle (
    .clk(clk_i), .rst(rst_i), .inc(1'b1),
    .wr_lo(commit && addr_q == CSR_MCYCLE), .wr_hi(commit && addr_q == CSR_MCYCLEH),
    .wdata(new_val), .lo(mcycle_lo), .hi(mcycle_hi)
  );

  csr_counter #(.W(CNT_WIDTH)) u_minstret (
    .clk(clk_i), .rst(rst_i), .inc(bus.instret_i),
    .wr_lo(commit && addr_q == CSR_MINSTRET), .wr_hi(commit && addr_q == CSR_MINSTRETH),
    .wdata(new_val), .lo(minstret_lo), .hi(minstret_hi)
  );
`else
  localparam int unused_cnt_width = CNT_WIDTH;
  logic unused_instret;
  assign unused_instret = bus.instret_i;
`endif

  always_comb begin
    rd_exists = 1'b1;
    rd_val    = '0;
    case (addr_q)
      CSR_MVENDORID:  rd_val = XLEN'(VENDOR_ID);
      CSR_MHARTID:    rd_val = XLEN'(HART_ID);
      CSR_MSTATUS:    rd_val = mstatus_q;
      CSR_MISA:       rd_val = MISA_VAL;
      CSR_MIE:        rd_val = mie_q;
      CSR_MTVEC:      rd_val = mtvec_q;
      CSR_MCOUNTEREN: rd_val = mcounteren_q;
      CSR_MSCRATCH:   rd_val = mscratch_q;
      CSR_MEPC:       rd_val = mepc_q;
      CSR_MCAUSE:     rd_val = mcause_q;
      CSR_MTVAL:      rd_val = mtval_q;
      CSR_MIP:        rd_val = mip_q;
      CSR_MTAGS:      rd_val = mtags_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:     rd_val = mcycle_lo;
      CSR_MINSTRET:   rd_val = minstret_lo;
      CSR_MCYCLEH:    rd_val = mcycle_hi;
      CSR_MINSTRETH:  rd_val = minstret_hi;
`endif
      default:        rd_exists = 1'b0;
    endcase
  end

  assign we      = csr_writes(op_q, wdata_q);
  assign illegal = !exists_q || (ro_q && we);
  assign commit  = (state_q == ST_WRITE) && we && !illegal;
  assign new_val = csr_apply(op_q, data_q, wdata_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q <= CSR_OP_READ;
      {addr_q, wdata_q, data_q, exists_q, ro_q, irq_clr_q} <= '0;
      {mstatus_q, mie_q, mtvec_q, mcounteren_q, mscratch_q} <= '0;
      {mepc_q, mcause_q, mtval_q, mip_q, mtags_q} <= '0;
    end else begin
      irq_clr_q <= 1'b0;
      if (state_q == ST_IDLE && bus.csr_en_i) begin
        addr_q  <= bus.csr_addr_i;
        op_q    <= csr_op_e'(bus.csr_op_i);
        wdata_q <= bus.csr_data_i;
      end
      if (state_q == ST_READ) begin
        data_q   <= rd_val;
        exists_q <= rd_exists;
        ro_q     <= (addr_q[ADDR_WIDTH-1 -: 2] == 2'b11);
      end
      // misa and the counters are absent here: misa ignores writes, counters own their state.
      if (commit) begin
        case (addr_q)
          CSR_MSTATUS:    mstatus_q    <= new_val;
          CSR_MIE:        mie_q        <= new_val;
          CSR_MTVEC:      mtvec_q      <= new_val;
          CSR_MCOUNTEREN: mcounteren_q <= new_val;
          CSR_MSCRATCH:   mscratch_q   <= new_val;
          CSR_MEPC:       mepc_q       <= new_val;
          CSR_MCAUSE:     mcause_q     <= new_val;
          CSR_MTVAL:      mtval_q      <= new_val;
          CSR_MIP:        mip_q        <= new_val;
          CSR_MTAGS: begin
            mtags_q   <= new_val;
            irq_clr_q <= new_val[MTAGS_IRQ_CLR];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.csr_data_o           = data_q;
  assign bus.csr_busy_o           = (state_q != ST_IDLE);
  assign bus.csr_done_o           = (state_q == ST_WRITE);
  assign bus.csr_illegal_o        = (state_q == ST_WRITE) && illegal;
  assign bus.csr_irq_en_o         = mstatus_q[MSTATUS_MIE];
  assign bus.csr_tags_en_o        = mtags_q[MTAGS_EN];
  assign bus.csr_tags_if_en_o     = mtags_q[MTAGS_IF_EN];
  assign bus.csr_tags_irq_clear_o = irq_clr_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed, table-driven bench for csr_file; the counter section follows CSR_COUNTERS_EN.
module tb_csr_file;
  import csr_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  csr_if #(.XLEN(32), .ADDR_WIDTH(12)) bus ();

  csr_file dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] d;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] d,
                              input logic [31:0] exp_data, input logic exp_ill);
    vec_t v;
    v.op = op; v.addr = addr; v.d = d; v.exp_data = exp_data; v.exp_ill = exp_ill;
    vecs.push_back(v);
  endfunction

  // Issues one request, checks busy and 2-cycle latency, returns the done-cycle response.
  // Returns one cycle after done, when side-band outputs have taken the commit.
  task automatic req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] d,
                     output logic [31:0] rd, output logic ill);
    int lat;
    @(negedge clk);
    bus.csr_en_i   = 1'b1;
    bus.csr_op_i   = op;
    bus.csr_addr_i = addr;
    bus.csr_data_i = d;
    @(posedge clk); #1;
    bus.csr_en_i = 1'b0;
    check("busy_after_accept", 32'(bus.csr_busy_o), 32'd1);
    lat = 1;
    while (!bus.csr_done_o && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", 32'(lat), 32'd2);
    rd  = bus.csr_data_o;
    ill = bus.csr_illegal_o;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.csr_done_o), 32'd0);
  endtask

  logic [31:0] rd;
  logic        ill;
  int          ndone, first, gap;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.csr_en_i = 1'b0; bus.csr_op_i = 2'b00; bus.csr_addr_i = '0;
    bus.csr_data_i = '0; bus.instret_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.csr_busy_o), 32'd0);
    check("rst_done", 32'(bus.csr_done_o), 32'd0);
    check("rst_illegal", 32'(bus.csr_illegal_o), 32'd0);
    check("rst_data", bus.csr_data_o, 32'd0);
    check("rst_sideband", {28'd0, bus.csr_irq_en_o, bus.csr_tags_en_o,
                           bus.csr_tags_if_en_o, bus.csr_tags_irq_clear_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    add(CSR_OP_READ, 12'hF14, 32'h0,          32'h0,          1'b0);
    add(CSR_OP_READ, 12'h301, 32'h0,          32'h40000100,   1'b0);
    add(CSR_OP_READ, 12'h123, 32'h0,          32'h0,          1'b1);
    add(CSR_OP_READ, 12'hF11, 32'h0,          32'h0,          1'b0);
    add(CSR_OP_RW,   12'h340, 32'hDEADBEEF,   32'h0,          1'b0);
    add(CSR_OP_RS,   12'h340, 32'h000000F0,   32'hDEADBEEF,   1'b0);
    add(CSR_OP_READ, 12'h340, 32'h0,          32'hDEADBEFF,   1'b0);
    add(CSR_OP_RC,   12'h340, 32'h0000000F,   32'hDEADBEFF,   1'b0);
    add(CSR_OP_READ, 12'h340, 32'h0,          32'hDEADBEF0,   1'b0);
    add(CSR_OP_RW,   12'hF11, 32'h1,          32'h0,          1'b1);
    add(CSR_OP_RS,   12'hF11, 32'h0,          32'h0,          1'b0);
    add(CSR_OP_RC,   12'hF14, 32'h0,          32'h0,          1'b0);
    add(CSR_OP_RS,   12'hF14, 32'h1,          32'h0,          1'b1);
    add(CSR_OP_RW,   12'h301, 32'h12345678,   32'h40000100,   1'b0);
    add(CSR_OP_READ, 12'h301, 32'h0,          32'h40000100,   1'b0);
    add(CSR_OP_RW,   12'h342, 32'hAAAA5555,   32'h0,          1'b0);
    add(CSR_OP_RC,   12'h342, 32'hFFFF0000,   32'hAAAA5555,   1'b0);
    add(CSR_OP_RS,   12'h342, 32'h0,          32'h00005555,   1'b0);
    add(CSR_OP_RW,   12'h7FF, 32'h1,          32'h0,          1'b1);
    add(CSR_OP_READ, 12'h340, 32'h0,          32'hDEADBEF0,   1'b0);
    add(CSR_OP_RW,   12'h304, 32'h11,         32'h0,          1'b0);
    add(CSR_OP_RW,   12'h305, 32'h22,         32'h0,          1'b0);
    add(CSR_OP_RW,   12'h306, 32'h33,         32'h0,          1'b0);
    add(CSR_OP_RW,   12'h341, 32'h44,         32'h0,          1'b0);
    add(CSR_OP_RW,   12'h343, 32'h55,         32'h0,          1'b0);
    add(CSR_OP_RW,   12'h344, 32'h66,         32'h0,          1'b0);
    add(CSR_OP_READ, 12'h304, 32'h0,          32'h11,         1'b0);
    add(CSR_OP_READ, 12'h305, 32'h0,          32'h22,         1'b0);
    add(CSR_OP_READ, 12'h306, 32'h0,          32'h33,         1'b0);
    add(CSR_OP_READ, 12'h341, 32'h0,          32'h44,         1'b0);
    add(CSR_OP_READ, 12'h343, 32'h0,          32'h55,         1'b0);
    add(CSR_OP_READ, 12'h344, 32'h0,          32'h66,         1'b0);
    add(CSR_OP_READ, 12'h342, 32'h0,          32'h00005555,   1'b0);
`ifndef CSR_COUNTERS_EN
    add(CSR_OP_READ, 12'hB00, 32'h0,          32'h0,          1'b1);
    add(CSR_OP_RW,   12'hB82, 32'h5,          32'h0,          1'b1);
`endif

    foreach (vecs[i]) begin
      req(vecs[i].op, vecs[i].addr, vecs[i].d, rd, ill);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vecs[i].exp_ill));
    end

    req(CSR_OP_RS, 12'h300, 32'h8, rd, ill);
    check("irq_en_set", 32'(bus.csr_irq_en_o), 32'd1);
    req(CSR_OP_RC, 12'h300, 32'h8, rd, ill);
    check("irq_en_clear_old", rd, 32'h8);
    check("irq_en_clear", 32'(bus.csr_irq_en_o), 32'd0);

    req(CSR_OP_RW, 12'h7C0, 32'h7, rd, ill);
    check("tags_en", 32'(bus.csr_tags_en_o), 32'd1);
    check("tags_if_en", 32'(bus.csr_tags_if_en_o), 32'd1);
    check("tags_irq_clear_pulse", 32'(bus.csr_tags_irq_clear_o), 32'd1);
    @(posedge clk); #1;
    check("tags_irq_clear_drop", 32'(bus.csr_tags_irq_clear_o), 32'd0);
    check("tags_en_hold", 32'(bus.csr_tags_en_o), 32'd1);
    check("data_held", bus.csr_data_o, 32'h0);
    req(CSR_OP_RW, 12'h7C0, 32'h5, rd, ill);
    check("tags_old", rd, 32'h7);
    check("tags_no_clear_pulse", 32'(bus.csr_tags_irq_clear_o), 32'd0);
    req(CSR_OP_RW, 12'h7C0, 32'h2, rd, ill);
    check("tags_en_off", 32'(bus.csr_tags_en_o), 32'd0);
    check("tags_if_en_off", 32'(bus.csr_tags_if_en_o), 32'd0);
    check("tags_irq_clear_again", 32'(bus.csr_tags_irq_clear_o), 32'd1);

    // csr_en_i held for six edges: accepts at the 1st and 4th, done on the 2nd and 5th.
    @(negedge clk);
    bus.csr_op_i = CSR_OP_READ; bus.csr_addr_i = 12'h301; bus.csr_data_i = '0;
    bus.csr_en_i = 1'b1;
    ndone = 0; first = -1; gap = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.csr_done_o) begin
        if (first < 0) first = i;
        else gap = i - first;
        ndone++;
      end
    end
    bus.csr_en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.csr_done_o) ndone++;
    end
    check("held_done_count", 32'(ndone), 32'd2);
    check("held_done_gap", 32'(gap), 32'd3);

    // Reset while the request sits in WRITE: no done may follow.
    req(CSR_OP_RS, 12'h300, 32'h8, rd, ill);
    check("irq_en_before_abort", 32'(bus.csr_irq_en_o), 32'd1);
    @(negedge clk);
    bus.csr_op_i = CSR_OP_RW; bus.csr_addr_i = 12'h340; bus.csr_data_i = 32'hFFFFFFFF;
    bus.csr_en_i = 1'b1;
    @(posedge clk); #1;
    bus.csr_en_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.csr_busy_o), 32'd0);
    check("abort_done", 32'(bus.csr_done_o), 32'd0);
    check("abort_irq_en", 32'(bus.csr_irq_en_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.csr_done_o) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    req(CSR_OP_READ, 12'h340, 32'h0, rd, ill);
    check("abort_mscratch", rd, 32'h0);

`ifdef CSR_COUNTERS_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.instret_i = 1'b1;
      @(negedge clk); bus.instret_i = 1'b0;
    end
    req(CSR_OP_READ, 12'hB02, 32'h0, rd, ill);
    check("minstret_five", rd, 32'd5);
    check("minstret_legal", 32'(ill), 32'd0);
    req(CSR_OP_RW, 12'hB02, 32'hFFFFFFFF, rd, ill);
    check("minstret_old", rd, 32'd5);
    req(CSR_OP_READ, 12'hB82, 32'h0, rd, ill);
    check("minstreth_no_carry", rd, 32'd0);
    req(CSR_OP_READ, 12'hB02, 32'h0, rd, ill);
    check("minstret_written", rd, 32'hFFFFFFFF);
    @(negedge clk); bus.instret_i = 1'b1;
    @(negedge clk); bus.instret_i = 1'b0;
    req(CSR_OP_READ, 12'hB02, 32'h0, rd, ill);
    check("minstret_wrap", rd, 32'd0);
    req(CSR_OP_READ, 12'hB82, 32'h0, rd, ill);
    check("minstreth_carry", rd, 32'd1);

    // Written cycle holds FFFFFFFF; the read's accept cycle increments it to lo=0.
    req(CSR_OP_RW, 12'hB00, 32'hFFFFFFFF, rd, ill);
    check("mcycle_write_legal", 32'(ill), 32'd0);
    req(CSR_OP_READ, 12'hB00, 32'h0, rd, ill);
    check("mcycle_wrapped", rd, 32'd0);
    req(CSR_OP_READ, 12'hB80, 32'h0, rd, ill);
    check("mcycleh_after_wrap", rd, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
